// File: rtl/hub75_pixel_rx_pkg.sv
// Shared types and helpers for the HUB75 pixel receiver.
package hub75_pkg;

  localparam int HUB75_AW         = 14;
  localparam int HUB75_DW         = 20;
  localparam int HUB75_NUM_PIXELS = 16384;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECV      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  // RGB888 -> RGB776: keep the 7 MSBs of R and G and the 6 MSBs of B.
  function automatic logic [HUB75_DW-1:0] pack_pixel(input logic [7:0] r,
                                                     input logic [7:0] g,
                                                     input logic [7:0] b);
    logic unused_lsbs;
    unused_lsbs = ^{r[0], g[0], b[1:0]};
    return {r[7:1], g[7:1], b[7:2]};
  endfunction

endpackage

// File: rtl/hub75_pixel_rx_if.sv
// Byte stream in, framebuffer write port out. The receiver uses the slave view.
interface hub75_pixel_rx_if
  import hub75_pkg::*;
#(
  parameter int AW = HUB75_AW,
  parameter int DW = HUB75_DW
) ();

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic [DW-1:0] fb_wdata;
  logic [AW-1:0] fb_waddr;
  logic          fb_we;

  modport master (
    output in_data, in_valid, in_sof,
    input  in_ready, fb_wdata, fb_waddr, fb_we
  );

  modport slave (
    input  in_data, in_valid, in_sof,
    output in_ready, fb_wdata, fb_waddr, fb_we
  );

endinterface

// File: rtl/hub75_pixel_rx_byte_assembler.sv
// Collects R, G, B bytes into one pixel. An accepted sof byte always restarts
// the accumulator as R of a new pixel. The strobe is combinational so the
// parent can register the framebuffer write one cycle after the B byte.
module hub75_byte_assembler (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_accept,
  input  logic       i_sof,
  input  logic       i_active,
  input  logic [7:0] i_data,
  output logic       o_pix_valid,
  output logic       o_resync,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b
);

  logic [1:0] r_cnt;
  logic [7:0] r_r;
  logic [7:0] r_g;

  // Track byte position within the pixel and hold R/G until B arrives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_r   <= '0;
      r_g   <= '0;
    end else if (i_accept && i_sof) begin
      r_r   <= i_data;
      r_cnt <= 2'd1;
    end else if (i_accept && i_active) begin
      case (r_cnt)
        2'd0: begin
          r_r   <= i_data;
          r_cnt <= 2'd1;
        end
        2'd1: begin
          r_g   <= i_data;
          r_cnt <= 2'd2;
        end
        default: r_cnt <= 2'd0;
      endcase
    end
  end

  assign o_pix_valid = i_accept && i_active && !i_sof && (r_cnt == 2'd2);
  assign o_resync    = i_accept && i_active && i_sof;
  assign o_r         = r_r;
  assign o_g         = r_g;
  assign o_b         = i_data;

endmodule

// File: rtl/hub75_pixel_rx.sv
// HUB75 framebuffer writer: packs RGB888 stream pixels into the back buffer
// and swaps the displayed buffer once a full frame has been written.
// Build option HUB75_RX_SWAP_SYNC_EN: when defined, the swap waits for the
// display's frame_start pulse; otherwise it happens one cycle after the last
// write (tearing possible).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready; discard bytes until one arrives with sof
// RECV      | assembling pixels and writing them at pix_cnt
// WAIT_SWAP | frame complete, stream stalled, waiting to swap buffers
module hub75_pixel_rx
  import hub75_pkg::*;
#(
  parameter int NUM_PIXELS = HUB75_NUM_PIXELS,
  parameter int AW         = HUB75_AW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_start,
  output logic             o_selection,
  output logic             o_frame_done,
  output logic             o_resync,
  hub75_pixel_rx_if.slave  bus
);

  localparam logic [AW-1:0] LAST_PIX = AW'(NUM_PIXELS - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_in_ready;
  logic                r_fb_we;
  logic [AW-1:0]       r_fb_waddr;
  logic [HUB75_DW-1:0] r_fb_wdata;
  logic [AW-1:0]       r_pix_cnt;
  logic                r_selection;
  logic                r_frame_done;
  logic                r_resync;

  logic                w_accept;
  logic                w_pix_valid;
  logic                w_resync;
  logic                w_last;
  logic                w_swap;
  logic [7:0]          w_r;
  logic [7:0]          w_g;
  logic [7:0]          w_b;

  assign w_accept = bus.in_valid && r_in_ready;

  hub75_byte_assembler u_asm (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_accept   (w_accept),
    .i_sof      (bus.in_sof),
    .i_active   (r_state == RECV),
    .i_data     (bus.in_data),
    .o_pix_valid(w_pix_valid),
    .o_resync   (w_resync),
    .o_r        (w_r),
    .o_g        (w_g),
    .o_b        (w_b)
  );

  assign w_last = w_pix_valid && (r_pix_cnt == LAST_PIX);

`ifdef HUB75_RX_SWAP_SYNC_EN
  // The cycle carrying the last write is already WAIT_SWAP; a frame_start
  // there must not swap, so it is masked by the pending write strobe.
  assign w_swap = (r_state == WAIT_SWAP) && i_frame_start && !r_fb_we;
`else
  logic w_unused_frame_start;
  assign w_unused_frame_start = i_frame_start;
  assign w_swap = (r_state == WAIT_SWAP);
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_accept && bus.in_sof) w_next = RECV;
      RECV:      if (w_last)                 w_next = WAIT_SWAP;
      WAIT_SWAP: if (w_swap)                 w_next = IDLE;
      default:                               w_next = IDLE;
    endcase
  end

  // Registered outputs, pixel addressing and buffer select.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_ready   <= 1'b0;
      r_fb_we      <= 1'b0;
      r_fb_waddr   <= '0;
      r_fb_wdata   <= '0;
      r_pix_cnt    <= '0;
      r_selection  <= 1'b0;
      r_frame_done <= 1'b0;
      r_resync     <= 1'b0;
    end else begin
      r_in_ready   <= (w_next != WAIT_SWAP);
      r_fb_we      <= w_pix_valid;
      r_frame_done <= w_swap;
      r_resync     <= w_resync;
      if (w_swap) r_selection <= ~r_selection;
      if (w_pix_valid) begin
        r_fb_waddr <= r_pix_cnt;
        r_fb_wdata <= pack_pixel(w_r, w_g, w_b);
      end
      if (w_accept && bus.in_sof) r_pix_cnt <= '0;
      else if (w_last)            r_pix_cnt <= '0;
      else if (w_pix_valid)       r_pix_cnt <= r_pix_cnt + AW'(1);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.fb_we     = r_fb_we;
  assign bus.fb_waddr  = r_fb_waddr;
  assign bus.fb_wdata  = r_fb_wdata;
  assign o_selection   = r_selection;
  assign o_frame_done  = r_frame_done;
  assign o_resync      = r_resync;

endmodule

// File: tb/tb_hub75_pixel_rx.sv
// Testbench for hub75_pixel_rx, run with a reduced frame size.
module tb_hub75_pixel_rx;

  localparam int NPIX = 64;
  localparam int AW   = 14;

  logic clk = 1'b0;
  logic rst;
  logic frame_start;
  logic selection, frame_done, resync;

  int n_checks = 0;
  int n_err    = 0;
  logic exp_sel = 1'b0;

  always #5 clk = ~clk;

  hub75_pixel_rx_if #(.AW(AW)) bus ();

  hub75_pixel_rx #(.NUM_PIXELS(NPIX), .AW(AW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_start(frame_start),
    .o_selection  (selection),
    .o_frame_done (frame_done),
    .o_resync     (resync),
    .bus          (bus)
  );

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        we;
    logic [13:0] addr;
    logic [19:0] wd;
    logic        rs;
  } vec_t;

  vec_t tbl[13];

  // Reference packing by arithmetic: 7 bits R, 7 bits G, 6 bits B.
  function automatic logic [19:0] ref_pack(input int r, input int g, input int b);
    return 20'((r / 2) * 8192 + (g / 2) * 64 + (b / 4));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    exp_sel = 1'b0;
  endtask

  // Pixel p carries bytes 3p, 3p+1, 3p+2 (mod 256).
  task automatic send_frame(input logic fs_at_last);
    int lr, lg, lb;
    for (int p = 0; p < NPIX; p++) begin
      cyc(1'b1, p == 0, 8'(p * 3));
      cyc(1'b1, 1'b0,   8'(p * 3 + 1));
      cyc(1'b1, 1'b0,   8'(p * 3 + 2));
    end
    lr = (3 * (NPIX - 1)) % 256;
    lg = (3 * (NPIX - 1) + 1) % 256;
    lb = (3 * (NPIX - 1) + 2) % 256;
    chk("last_we",    32'(bus.fb_we),    32'(1));
    chk("last_addr",  32'(bus.fb_waddr), 32'(NPIX - 1));
    chk("last_data",  32'(bus.fb_wdata), 32'(ref_pack(lr, lg, lb)));
    chk("ready_drop", 32'(bus.in_ready), 32'(0));
    chk("sel_at_last", 32'(selection),   32'(exp_sel));
    bus.in_valid = 1'b0;
    frame_start  = fs_at_last;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
`ifdef HUB75_RX_SWAP_SYNC_EN
    chk("no_swap_sel",  32'(selection),    32'(exp_sel));
    chk("no_swap_done", 32'(frame_done),   32'(0));
    chk("no_swap_rdy",  32'(bus.in_ready), 32'(0));
`else
    exp_sel = ~exp_sel;
    chk("auto_swap_sel",  32'(selection),    32'(exp_sel));
    chk("auto_swap_done", 32'(frame_done),   32'(1));
    chk("auto_swap_rdy",  32'(bus.in_ready), 32'(1));
    idle_cycles(1);
    chk("auto_done_low",  32'(frame_done),   32'(0));
`endif
  endtask

`ifdef HUB75_RX_SWAP_SYNC_EN
  task automatic swap_pulse();
    idle_cycles(3);
    chk("hold_sel",  32'(selection),    32'(exp_sel));
    chk("hold_rdy",  32'(bus.in_ready), 32'(0));
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    exp_sel = ~exp_sel;
    chk("swap_sel",  32'(selection),    32'(exp_sel));
    chk("swap_done", 32'(frame_done),   32'(1));
    chk("swap_rdy",  32'(bus.in_ready), 32'(1));
    idle_cycles(1);
    chk("done_low",  32'(frame_done),   32'(0));
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = 8'h00;
    frame_start  = 1'b0;
    rst          = 1'b1;

    // ---------------- reset values ----------------
    #2;
    chk("rst_ready", 32'(bus.in_ready), 32'(0));
    chk("rst_we",    32'(bus.fb_we),    32'(0));
    chk("rst_addr",  32'(bus.fb_waddr), 32'(0));
    chk("rst_data",  32'(bus.fb_wdata), 32'(0));
    chk("rst_sel",   32'(selection),    32'(0));
    chk("rst_done",  32'(frame_done),   32'(0));
    chk("rst_rsync", 32'(resync),       32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rdy_before_clk", 32'(bus.in_ready), 32'(0));
    @(posedge clk);
    #1;
    chk("rdy_after_clk",  32'(bus.in_ready), 32'(1));

    // ---------------- table-driven vectors ----------------
    tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 14'd0, 20'h00000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h22, 1'b0, 14'd0, 20'h00000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 14'd0, 20'h00000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h80, 1'b0, 14'd0, 20'h00000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h04, 1'b1, 14'd0, 20'hFF001, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h99, 1'b0, 14'd0, 20'h00000, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h12, 1'b0, 14'd0, 20'h00000, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h34, 1'b0, 14'd0, 20'h00000, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h56, 1'b1, 14'd1, 20'h12695, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'hAA, 1'b0, 14'd0, 20'h00000, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'h01, 1'b0, 14'd0, 20'h00000, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 8'h02, 1'b0, 14'd0, 20'h00000, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'h03, 1'b1, 14'd0, 20'h00040, 1'b0};
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].d);
      chk("tbl_we",     32'(bus.fb_we),    32'(tbl[i].we));
      chk("tbl_resync", 32'(resync),       32'(tbl[i].rs));
      chk("tbl_ready",  32'(bus.in_ready), 32'(1));
      if (tbl[i].we) begin
        chk("tbl_addr", 32'(bus.fb_waddr), 32'(tbl[i].addr));
        chk("tbl_data", 32'(bus.fb_wdata), 32'(tbl[i].wd));
      end
    end

    // ---------------- resync after 5 pixels + 1 byte ----------------
    do_reset();
    for (int p = 0; p < 5; p++) begin
      cyc(1'b1, p == 0, 8'h10);
      cyc(1'b1, 1'b0,   8'h20);
      cyc(1'b1, 1'b0,   8'h30);
    end
    chk("p4_addr", 32'(bus.fb_waddr), 32'(4));
    cyc(1'b1, 1'b0, 8'h40);
    cyc(1'b1, 1'b1, 8'hC8);
    chk("rs_pulse", 32'(resync), 32'(1));
    cyc(1'b1, 1'b0, 8'h64);
    chk("rs_low",   32'(resync), 32'(0));
    cyc(1'b1, 1'b0, 8'h0C);
    chk("rs_we",    32'(bus.fb_we),    32'(1));
    chk("rs_addr",  32'(bus.fb_waddr), 32'(0));
    chk("rs_data",  32'(bus.fb_wdata), 32'(ref_pack(200, 100, 12)));

    // ---------------- 10 bytes without sof in IDLE ----------------
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 8'(i * 17));
      chk("idle_we",  32'(bus.fb_we),    32'(0));
      chk("idle_rdy", 32'(bus.in_ready), 32'(1));
    end

    // ---------------- full frame, swap ----------------
    do_reset();
    send_frame(1'b0);
`ifdef HUB75_RX_SWAP_SYNC_EN
    swap_pulse();
`endif

    // ---------------- async reset mid-frame with selection=1 ----------------
    chk("sel_before_rst", 32'(selection), 32'(1));
    cyc(1'b1, 1'b1, 8'h55);
    cyc(1'b1, 1'b0, 8'h66);
    cyc(1'b1, 1'b0, 8'h77);
    cyc(1'b1, 1'b0, 8'h88);
    cyc(1'b1, 1'b0, 8'h99);
    cyc(1'b1, 1'b0, 8'hAA);
    chk("pre_rst_addr", 32'(bus.fb_waddr), 32'(1));
    #1 rst = 1'b1;
    #1;
    exp_sel = 1'b0;
    chk("arst_ready", 32'(bus.in_ready), 32'(0));
    chk("arst_we",    32'(bus.fb_we),    32'(0));
    chk("arst_addr",  32'(bus.fb_waddr), 32'(0));
    chk("arst_data",  32'(bus.fb_wdata), 32'(0));
    chk("arst_sel",   32'(selection),    32'(0));
    chk("arst_done",  32'(frame_done),   32'(0));
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_rdy_back", 32'(bus.in_ready), 32'(1));

`ifdef HUB75_RX_SWAP_SYNC_EN
    // ---------------- frame_start coinciding with last write ----------------
    send_frame(1'b1);
    idle_cycles(100);
    chk("late_hold_sel", 32'(selection), 32'(exp_sel));
    swap_pulse();
`endif

    // ---------------- randomized stream vs reference model ----------------
    begin
      int k;
      int mr, mg;
      logic v, s, e_we, e_rs;
      logic [7:0] d;
      int e_addr;
      logic [19:0] e_data;
      k = -1;
      mr = 0;
      mg = 0;
      for (int it = 0; it < 400; it++) begin
        v = ($urandom_range(0, 3) != 0);
        if (k < 0) s = v && ($urandom_range(0, 3) == 0);
        else       s = v && (($urandom_range(0, 29) == 0) || (k >= 3 * (NPIX - 2)));
        d = 8'($urandom);
        frame_start = ($urandom_range(0, 7) == 0);
        e_we = 1'b0;
        e_rs = 1'b0;
        e_addr = 0;
        e_data = '0;
        if (v) begin
          if (s) begin
            e_rs = (k >= 0);
            k = 1;
            mr = int'(d);
          end else if (k >= 0) begin
            if (k % 3 == 0) mr = int'(d);
            else if (k % 3 == 1) mg = int'(d);
            else begin
              e_we = 1'b1;
              e_addr = k / 3;
              e_data = ref_pack(mr, mg, int'(d));
            end
            k++;
          end
        end
        cyc(v, s, d);
        chk("rnd_we",     32'(bus.fb_we),    32'(e_we));
        chk("rnd_resync", 32'(resync),       32'(e_rs));
        chk("rnd_ready",  32'(bus.in_ready), 32'(1));
        chk("rnd_sel",    32'(selection),    32'(exp_sel));
        if (e_we) begin
          chk("rnd_addr", 32'(bus.fb_waddr), 32'(e_addr));
          chk("rnd_data", 32'(bus.fb_wdata), 32'(e_data));
        end
      end
      frame_start = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
